// File: rtl/x9_pkg.sv
// rtl/x9_pkg.sv - shared types and default widths for the X9 fetch stage
package x9_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } fetch_state_t;

    // Opcode of the branch-on-flag instruction; the decoder matches it to raise BranchInst.
    localparam logic [4:0] OP_BT = 5'b00101;

    localparam int DEF_PCW  = 10;
    localparam int DEF_LUTW = 4;
    localparam int DEF_CNTW = 16;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, branch and LUT-write bundle of the fetch stage
interface fetch_unit_if #(
    parameter int PCW  = x9_pkg::DEF_PCW,
    parameter int LUTW = x9_pkg::DEF_LUTW,
    parameter int CNTW = x9_pkg::DEF_CNTW
);

    logic            Start;
    logic [PCW-1:0]  StartAddr;
    logic [PCW-1:0]  EndAddr;
    logic            BranchInst;
    logic            BranchTaken;
    logic [LUTW-1:0] BranchIdx;
    logic            LutWe;
    logic [LUTW-1:0] LutAddr;
    logic [PCW-1:0]  LutData;
    logic [PCW-1:0]  ProgCtr;
    logic            Done;
    logic [CNTW-1:0] CycleCnt;

    modport master (
        output Start, StartAddr, EndAddr,
        output BranchInst, BranchTaken, BranchIdx,
        output LutWe, LutAddr, LutData,
        input  ProgCtr, Done, CycleCnt
    );

    modport slave (
        input  Start, StartAddr, EndAddr,
        input  BranchInst, BranchTaken, BranchIdx,
        input  LutWe, LutAddr, LutData,
        output ProgCtr, Done, CycleCnt
    );

endinterface

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch target table, one synchronous write port, one combinational read port
module branch_lut
    import x9_pkg::*;
#(
    parameter int LUTW = DEF_LUTW,
    parameter int PCW  = DEF_PCW
) (
    input  logic            clk,
    input  logic            we,
    input  logic [LUTW-1:0] waddr,
    input  logic [PCW-1:0]  wdata,
    input  logic [LUTW-1:0] raddr,
    output logic [PCW-1:0]  rdata
);

    // Not reset: targets are loaded by software before use.
    logic [PCW-1:0] mem [2**LUTW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle write to the read index still returns the old entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - X9 instruction fetch: PC register, next-PC mux, run sequencer and cycle counter
module fetch_unit
    import x9_pkg::*;
#(
    parameter int PCW  = DEF_PCW,
    parameter int LUTW = DEF_LUTW,
    parameter int CNTW = DEF_CNTW
) (
    input  logic       Clk,
    input  logic       Reset,
    fetch_unit_if.slave bus
);

    fetch_state_t    state, state_n;
    logic [PCW-1:0]  pc, pc_n;
    logic            done, done_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [PCW-1:0]  lut_target;

    branch_lut #(
        .LUTW (LUTW),
        .PCW  (PCW)
    ) u_branch_lut (
        .clk   (Clk),
        .we    (bus.LutWe),
        .waddr (bus.LutAddr),
        .wdata (bus.LutData),
        .raddr (bus.BranchIdx),
        .rdata (lut_target)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            done  <= done_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        done_n  = done;
        cnt_n   = cnt;
        if (bus.Start) begin
            state_n = LOAD;
            pc_n    = bus.StartAddr;
            done_n  = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    done_n = 1'b0;
                end
                LOAD: begin
                    state_n = RUN;
                end
                RUN: begin
                    if (!(&cnt)) begin
                        cnt_n = cnt + CNTW'(1);
                    end
                    // Reaching the end address wins over any branch on the final instruction.
                    if (pc == bus.EndAddr) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (bus.BranchInst && bus.BranchTaken) begin
                        pc_n = lut_target;
                    end else begin
                        pc_n = pc + PCW'(1);
                    end
                end
                DONE: begin
                    done_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.ProgCtr  = pc;
    assign bus.Done     = done;
    assign bus.CycleCnt = cnt;

endmodule
